med_reminder_table_ctrl: RTL
============================

Name: med_reminder_table_ctrl

Overview:
Parametrised successor to the single-entry RAM2 controller. It owns an internal table of DEPTH reminder entries, indexed by MedID; each entry holds a valid bit, a reload period and a time-remaining count. Write, read and clear commands operate on single entries. A Tick pulse from the timebase starts a sweep FSM that decrements every valid entry and raises a Due handshake to the alarm/display logic whenever a medicine falls due.

Parameters:
ID_W, 4, MedID width; table depth DEPTH = 2**ID_W
TIME_W, 4, width of the period and time-remaining fields

Ports:
Clk  in  1  system clock, rising edge
Rst  in  1  asynchronous, active-low reset
Write_Enable  in  1  store entry {Period_In, TimeRem_In} at MedID_In and set its valid bit
Read_Enable  in  1  query the entry at MedID_In
Clear_Enable  in  1  invalidate the entry at MedID_In
MedID_In  in  ID_W  command index
TimeRem_In  in  TIME_W  initial time remaining
Period_In  in  TIME_W  reload period; 0 means one-shot
Tick  in  1  one-cycle pulse that starts a sweep
Due_Ack  in  1  consumer accepts the current Due entry
Busy  out  1  high when FSM is not IDLE
Read_Valid  out  1  one-cycle pulse, read data valid
Entry_Valid_Out  out  1  valid bit of the read entry
TimeRem_Out  out  TIME_W  time remaining of the read entry
Period_Out  out  TIME_W  period of the read entry
Due_Valid  out  1  a medicine is due; held until Due_Ack
Due_MedID  out  ID_W  index of the due medicine
Tick_Overrun  out  1  one-cycle pulse, Tick dropped because FSM was busy

Behaviour:
- Rst=0 (async): all valid bits cleared; FSM to IDLE; sweep index 0; every output 0. Reset during a sweep aborts it, and no Due is issued afterwards.
- Table fields need not reset; only the valid bits are reset.
- FSM states: IDLE, SWEEP, DUE_WAIT. Busy = (state != IDLE).
- Commands are accepted only in IDLE. Priority: Clear > Write > Read. A command received while Busy=1 is ignored: no table change, no Read_Valid.
- Write: takes effect at the clock edge. Read data is visible from the next cycle.
- Read: Read_Valid pulses one cycle after Read_Enable.
  - Valid entry: outputs its contents.
  - Invalid entry: Entry_Valid_Out=0, TimeRem_Out=0, Period_Out=0.
  - TimeRem_Out, Period_Out and Entry_Valid_Out hold their values until the next read.
- Tick in IDLE: go to SWEEP next cycle with index=0. A command in the same cycle executes first, and the sweep sees its result.
- Tick in SWEEP or DUE_WAIT: the tick is dropped and Tick_Overrun pulses one cycle.
- SWEEP processes one index per cycle:
  - Invalid entry: skip.
  - Valid entry with remaining > 1: remaining <= remaining - 1.
  - Valid entry with remaining <= 1: due. If Period != 0, remaining <= Period; if Period == 0, valid <= 0. Then Due_Valid <= 1, Due_MedID <= index, state <= DUE_WAIT.
- After processing index DEPTH-1 with no due: IDLE next cycle.
- DUE_WAIT: Due_Valid and Due_MedID are held stable. On Due_Ack, Due_Valid <= 0; resume SWEEP at index+1, or go to IDLE if the index was DEPTH-1.
- Due_Ack outside DUE_WAIT is ignored.
- Sweep timing: DEPTH cycles plus the cycles spent waiting for acks. The index wraps only by returning to IDLE.
- All arithmetic is unsigned, TIME_W bits wide. Because the due test is remaining <= 1, the count never underflows.

Test Plan:
- Reset, then Write MedID=3, TimeRem=5, Period=6; Read MedID=3 -> next cycle Read_Valid=1, Entry_Valid_Out=1, TimeRem_Out=5, Period_Out=6. Read MedID=4 -> Entry_Valid_Out=0, TimeRem_Out=0, Period_Out=0.
- Entry 3 as above, one Tick -> Busy for 16 cycles, no Due; Read MedID=3 -> TimeRem_Out=4.
- Write MedID=2, TimeRem=1, Period=3; Tick -> Due_Valid=1, Due_MedID=2, Busy held. Wait 5 cycles, then Due_Ack -> sweep resumes at index 3 and finishes. Read MedID=2 -> TimeRem_Out=3.
- Write MedID=7, TimeRem=0, Period=0; Tick + Ack -> Due_MedID=7; Read MedID=7 -> Entry_Valid_Out=0 (one-shot cleared).
- Tick during a sweep -> Tick_Overrun pulse and no second sweep. Write MedID=5 while Busy -> Read MedID=5 after the sweep gives Entry_Valid_Out=0.
- Assert Rst=0 mid-sweep while in DUE_WAIT -> Due_Valid=0 and Busy=0 immediately, and all entries read back invalid.

Source files
------------

// File: rtl/med_reminder_table_ctrl.sv
// Reminder table controller: DEPTH entries of {valid, period, remaining}, single-entry
// commands while idle, and a tick-driven sweep that counts entries down and hands out due events.

module med_reminder_entry #(
  parameter int TIME_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              wr,
  input  logic              clr,
  input  logic              hit,
  input  logic [TIME_W-1:0] period_in,
  input  logic [TIME_W-1:0] rem_in,
  output logic              valid,
  output logic [TIME_W-1:0] period,
  output logic [TIME_W-1:0] rem
);
  logic due;
  assign due = (rem <= TIME_W'(1));

  always_ff @(posedge Clk or negedge Rst)
    if (!Rst)                                 valid <= 1'b0;
    else if (clr)                             valid <= 1'b0;
    else if (wr)                              valid <= 1'b1;
    else if (hit && valid && due && period == '0) valid <= 1'b0;

  // Payload is left unreset; it is only ever observed through the valid bit.
  always_ff @(posedge Clk)
    if (wr) begin
      period <= period_in;
      rem    <= rem_in;
    end else if (hit && valid) begin
      rem <= due ? period : rem - 1'b1;
    end
endmodule

module med_reminder_table_ctrl #(
  parameter int ID_W   = 4,
  parameter int TIME_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Write_Enable,
  input  logic              Read_Enable,
  input  logic              Clear_Enable,
  input  logic [ID_W-1:0]   MedID_In,
  input  logic [TIME_W-1:0] TimeRem_In,
  input  logic [TIME_W-1:0] Period_In,
  input  logic              Tick,
  input  logic              Due_Ack,
  output logic              Busy,
  output logic              Read_Valid,
  output logic              Entry_Valid_Out,
  output logic [TIME_W-1:0] TimeRem_Out,
  output logic [TIME_W-1:0] Period_Out,
  output logic              Due_Valid,
  output logic [ID_W-1:0]   Due_MedID,
  output logic              Tick_Overrun
);
  localparam int DEPTH = 1 << ID_W;

  typedef enum logic [1:0] {IDLE, SWEEP, DUE_WAIT} state_t;

  state_t                        state, state_nxt;
  logic [ID_W-1:0]               idx, idx_nxt;
  logic                          due_set, due_clr;
  logic [DEPTH-1:0]              valid;
  logic [DEPTH-1:0][TIME_W-1:0]  period, rem;
  logic                          idle, clr_cmd, wr_cmd, rd_cmd, cur_due, last;

  assign idle    = (state == IDLE);
  assign Busy    = !idle;
  assign clr_cmd = idle && Clear_Enable;
  assign wr_cmd  = idle && !Clear_Enable && Write_Enable;
  assign rd_cmd  = idle && !Clear_Enable && !Write_Enable && Read_Enable;
  assign cur_due = valid[idx] && (rem[idx] <= TIME_W'(1));
  assign last    = &idx;

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    med_reminder_entry #(.TIME_W(TIME_W)) u_ent (
      .Clk      (Clk),
      .Rst      (Rst),
      .wr       (wr_cmd && MedID_In == ID_W'(i)),
      .clr      (clr_cmd && MedID_In == ID_W'(i)),
      .hit      (state == SWEEP && idx == ID_W'(i)),
      .period_in(Period_In),
      .rem_in   (TimeRem_In),
      .valid    (valid[i]),
      .period   (period[i]),
      .rem      (rem[i])
    );
  end

  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    due_set   = 1'b0;
    due_clr   = 1'b0;
    case (state)
      IDLE:
        if (Tick) begin
          state_nxt = SWEEP;
          idx_nxt   = '0;
        end
      SWEEP:
        if (cur_due) begin
          state_nxt = DUE_WAIT;
          due_set   = 1'b1;
        end else if (last) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt   = idx + 1'b1;
        end
      DUE_WAIT:
        if (Due_Ack) begin
          due_clr   = 1'b1;
          state_nxt = last ? IDLE : SWEEP;
          idx_nxt   = last ? '0 : idx + 1'b1;
        end
      default: state_nxt = IDLE;
    endcase
  end

  // Due handshake and tick-overrun flag
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      Due_Valid    <= 1'b0;
      Due_MedID    <= '0;
      Tick_Overrun <= 1'b0;
    end else begin
      Tick_Overrun <= Tick && !idle;
      if (due_set) begin
        Due_Valid <= 1'b1;
        Due_MedID <= idx;
      end else if (due_clr) begin
        Due_Valid <= 1'b0;
      end
    end

  // Read response; data holds until the next accepted read
  always_ff @(posedge Clk or negedge Rst)
    if (!Rst) begin
      Read_Valid      <= 1'b0;
      Entry_Valid_Out <= 1'b0;
      TimeRem_Out     <= '0;
      Period_Out      <= '0;
    end else begin
      Read_Valid <= rd_cmd;
      if (rd_cmd) begin
        Entry_Valid_Out <= valid[MedID_In];
        TimeRem_Out     <= valid[MedID_In] ? rem[MedID_In]    : '0;
        Period_Out      <= valid[MedID_In] ? period[MedID_In] : '0;
      end
    end
endmodule
